// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the 8N1 UART receiver and transmitter.
//   DATA_BITS       - payload bits per frame
//   uart_state_e    - receiver FSM state encoding
//   uart_bit_cycles - clock cycles per bit for a given clock and baud rate
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  function automatic int uart_bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for asynchronous inputs.
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, loads RESET_VAL into both flops
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clock cycles of latency)
module uart_rx_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (START=0, D0..D7 LSB first, STOP=1).
//   clk       - system clock
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idles high
//   data_out  - last correctly framed byte
//   valid     - one-cycle strobe: data_out was just updated
//   frame_err - one-cycle strobe: stop bit sampled low
//   busy      - high while a frame is being received
//   state_dbg - current receiver FSM state, for observation only
//
// Output semantics: valid is a pure strobe with no back-pressure. It is high
// for exactly one cycle, in the cycle data_out holds the new byte; the
// consumer must capture data_out in that cycle because the next frame will
// overwrite it. valid and frame_err are never high together.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        frame_err,
  output logic        busy,
  output uart_state_e state_dbg
);

  localparam int BIT  = uart_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;

  uart_rx_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  assign cnt_d = cnt_q + 1'b1;

  // Every state transition below clears cnt_q so each state measures its
  // own interval from entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            // Shift in at the MSB so that after eight bits bit k sits in [k].
            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              // Straight back to IDLE so a start bit right after stop is caught.
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT_IDLE: begin
          // Line held low (break): wait for it to return high before hunting.
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Main instance runs at BIT=10 cycles; two default-rate instances check the
// +/-3% baud tolerance. The model schedules expected strobes, busy intervals
// and bytes per cycle from frame timing arithmetic.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT  = 10;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic [7:0] data_out;
  logic valid, frame_err, busy;
  uart_state_e st_main;

  logic rx_fast = 1'b1;
  logic rx_slow = 1'b1;
  logic [7:0] d_f, d_s;
  logic v_f, v_s, fe_f, fe_s, b_f, b_s;
  uart_state_e st_f, st_s;

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
    .frame_err(frame_err), .busy(busy), .state_dbg(st_main)
  );

  uart_rx dut_fast (
    .clk(clk), .rst(rst), .rx(rx_fast), .data_out(d_f), .valid(v_f),
    .frame_err(fe_f), .busy(b_f), .state_dbg(st_f)
  );

  uart_rx dut_slow (
    .clk(clk), .rst(rst), .rx(rx_slow), .data_out(d_s), .valid(v_s),
    .frame_err(fe_s), .busy(b_s), .state_dbg(st_s)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // counts
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // model state
  logic [7:0] exp_q[$];
  bit         ev_kind[int];   // 0 = valid strobe, 1 = frame error strobe
  bit         ev_rst[int];
  int         busy_lo[$];
  int         busy_hi[$];
  logic [7:0] model_data = 8'h00;
  int         valid_cyc[$];
  int         ferr_cnt = 0;
  bit         checking = 1'b0;

  // per-cycle compare of the main instance
  always @(negedge clk) begin
    if (checking) begin
      int p;
      logic exp_v, exp_f, exp_b;
      p = cyc;
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      if (ev_rst.exists(p)) begin
        model_data = 8'h00;
        ev_rst.delete(p);
      end
      if (ev_kind.exists(p)) begin
        if (ev_kind[p] == 1'b0) begin
          exp_v = 1'b1;
          if (exp_q.size() > 0) model_data = exp_q.pop_front();
        end else begin
          exp_f = 1'b1;
        end
        ev_kind.delete(p);
      end
      foreach (busy_lo[i])
        if (p >= busy_lo[i] && p <= busy_hi[i]) exp_b = 1'b1;
      chk("valid", {31'd0, valid}, {31'd0, exp_v});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_f});
      chk("busy", {31'd0, busy}, {31'd0, exp_b});
      chk("data_out", {24'd0, data_out}, {24'd0, model_data});
      if (valid) valid_cyc.push_back(p);
      if (frame_err) ferr_cnt++;
    end
  end

  // tolerance-instance monitors
  int got_f = 0, got_s = 0, err_f = 0, err_s = 0;
  logic [7:0] dat_f = 8'h00, dat_s = 8'h00;
  always @(negedge clk) begin
    if (v_f) begin got_f++; dat_f = d_f; end
    if (v_s) begin got_s++; dat_s = d_s; end
    if (fe_f) err_f++;
    if (fe_s) err_s++;
  end

  // driver tasks: all start and end on a falling edge
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int hold_low, input int abort_at);
    logic [9:0] bits;
    int n, t, s, r;
    bits = {stop, b, 1'b0};
    n = cyc;
    t = n + 3;                   // two sync flops, then the FSM edge
    s = t + HALF + 9 * BIT;      // stop-bit sampling edge
    if (abort_at >= 0) begin
      busy_lo.push_back(t);
      busy_hi.push_back(n + abort_at);
      ev_rst[n + abort_at + 1] = 1'b1;
    end else if (stop) begin
      ev_kind[s] = 1'b0;
      exp_q.push_back(b);
      busy_lo.push_back(t);
      busy_hi.push_back(s - 1);
    end else begin
      ev_kind[s] = 1'b1;
      r = n + 10 * BIT + hold_low;
      busy_lo.push_back(t);
      busy_hi.push_back(r + 2);
    end
    for (int j = 0; j < 10 * BIT; j++) begin
      if (j == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rx = bits[j / BIT];
      @(negedge clk);
    end
    if (!stop) begin
      repeat (hold_low) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic glitch();
    int m;
    m = cyc;
    busy_lo.push_back(m + 3);
    busy_hi.push_back(m + 3 + HALF - 1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drive_tol(input int which, input int period);
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 10 * period; j++) begin
      if (which == 0) rx_fast = bits[j / period];
      else            rx_slow = bits[j / period];
      @(negedge clk);
    end
    if (which == 0) rx_fast = 1'b1;
    else            rx_slow = 1'b1;
  endtask

  // main sequence
  initial begin
    int n0, vc, ec, m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    chk("reset_data", {24'd0, data_out}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    idle(5);

    // ideal frame 0xA5
    n0 = cyc;
    send_frame(8'hA5, 1'b1, 0, -1);
    chk("a5_count", valid_cyc.size(), 1);
    chk("a5_latency", valid_cyc[$] - n0, 98);
    chk("a5_data", {24'd0, data_out}, 32'hA5);
    idle(4);

    // back-to-back 0x00, 0xFF
    n0 = cyc;
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    chk("b2b_count", valid_cyc.size(), 3);
    chk("b2b_first", valid_cyc[1] - n0, 98);
    chk("b2b_spacing", valid_cyc[2] - valid_cyc[1], 100);
    chk("b2b_data", {24'd0, data_out}, 32'hFF);
    idle(4);

    // glitch while idle
    vc = valid_cyc.size();
    ec = ferr_cnt;
    m  = cyc;
    glitch();
    idle(HALF + 3 - (cyc - m));
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    chk("glitch_no_valid", valid_cyc.size(), vc);
    chk("glitch_no_ferr", ferr_cnt, ec);
    idle(4);

    // bad stop bit, line held low
    ec = ferr_cnt;
    send_frame(8'h3C, 1'b0, 30, -1);
    chk("ferr_busy_held", {31'd0, busy}, 32'd1);
    idle(1);
    chk("ferr_busy_released", {31'd0, busy}, 32'd0);
    chk("ferr_count", ferr_cnt, ec + 1);
    chk("ferr_data_kept", {24'd0, data_out}, 32'hFF);
    idle(4);

    // reset during data bit 4 of 0x5A, then clean 0x81
    vc = valid_cyc.size();
    send_frame(8'h5A, 1'b1, 0, 5 * BIT + 3);
    idle(3);
    chk("abort_data_reset", {24'd0, data_out}, 32'h00);
    chk("abort_no_valid", valid_cyc.size(), vc);
    send_frame(8'h81, 1'b1, 0, -1);
    chk("after_abort_data", {24'd0, data_out}, 32'h81);
    idle(3);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, $urandom_range(0, 20), -1);
      idle($urandom_range(0, 12));
    end
    idle(20);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("events_drained", ev_kind.num(), 0);

    // baud tolerance at default rate: 3% fast and 3% slow, in parallel
    fork
      drive_tol(0, 5052);
      drive_tol(1, 5364);
    join
    idle(20);
    chk("tol_fast_count", got_f, 1);
    chk("tol_fast_data", {24'd0, dat_f}, 32'h55);
    chk("tol_fast_ferr", err_f, 0);
    chk("tol_slow_count", got_s, 1);
    chk("tol_slow_data", {24'd0, dat_s}, 32'h55);
    chk("tol_slow_ferr", err_s, 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d got timeout want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
